bitserial_link_driver: RTL and testbench
========================================

# bitserial_link_driver

Parallel-side driver for the bit-serial ALU datapath. It accepts one 32-bit operand pair plus an operation select through a valid/ready handshake and transmits both operands LSB-first, one bit per cycle, as framed serial streams. It then collects the bit-serial result, LSB-first, and presents it as a parallel word under a second valid/ready handshake. It sits between the register-file/decode side and the serial ALU, the counterpart of the ALU's shift-in/shift-out ends.

## Interface
- WIDTH, 32, operand/result width in bits (>= 2)
- w_clk  in  1  clock, all state updates on rising edge
- w_rst  in  1  synchronous, active-high reset
- w_in_valid  in  1  operand pair offered
- w_in_ready  out  1  driver can accept an operand pair
- w_rrs  in  WIDTH  operand A
- w_rrt  in  WIDTH  operand B
- w_sel  in  4  operation code (1 ADD, 2 SUB, 3 XOR, 4 OR, 5 AND), forwarded unchanged
- r_sa  out  1  serial bit of operand A
- r_sb  out  1  serial bit of operand B
- r_sv  out  1  serial bit valid
- r_sfirst  out  1  marks bit 0 of a frame
- r_slast  out  1  marks bit WIDTH-1 of a frame
- r_ssel  out  4  latched w_sel, stable for the whole transaction
- w_rbit  in  1  serial result bit, LSB first
- w_rv  in  1  result bit valid
- r_rslt  out  WIDTH  parallel result
- r_rslt_valid  out  1  r_rslt holds a complete result
- w_rslt_ready  in  1  consumer takes result

## Operation
- States: IDLE, SEND, WAIT, DONE.
- IDLE: w_in_ready=1. When w_in_valid=1, latch w_rrs, w_rrt, w_sel, clear tx and rx counters, go to SEND.
- SEND: each cycle drive r_sv=1, r_sa/r_sb = bit tx_cnt of the latched operands, and increment tx_cnt.
  - r_sfirst=1 only when tx_cnt=0. r_slast=1 only when tx_cnt=WIDTH-1.
  - After bit WIDTH-1, go to WAIT, or go directly to DONE if rx is already complete at that edge.
- Receive runs in SEND and WAIT. On every cycle with w_rv=1:
  - shift w_rbit into the MSB of the rx shift register (right shift);
  - increment rx_cnt.
  - When rx_cnt reaches WIDTH, copy the rx shift register into r_rslt.
- WAIT: when rx_cnt==WIDTH, go to DONE. Any further w_rv is ignored.
- DONE: r_rslt_valid=1. When w_rslt_ready=1, return to IDLE.
- w_rv in IDLE or DONE is ignored: no shift, no count.
- w_in_valid outside IDLE is ignored. w_in_ready=0 in SEND, WAIT and DONE, and during reset.
- rx bits beyond WIDTH in SEND are discarded (rx_cnt saturates at WIDTH).
- w_sel is passed through, never decoded. Unknown codes are forwarded as-is.

## Timing
- Reset values:
  - state IDLE;
  - w_in_ready=0 in the reset cycle, 1 from the following cycle;
  - r_sa, r_sb, r_sv, r_sfirst, r_slast = 0;
  - r_ssel=0;
  - r_rslt=0;
  - r_rslt_valid=0;
  - counters 0.
- Reset mid-transaction aborts at the next edge. Outputs return to reset values, and a partial result is never presented.
- Accept edge E0. Serial bit k appears registered in cycle E0+1+k, so the frame occupies cycles E0+1 .. E0+WIDTH.
- Serial outputs are registered. r_sv=0 and r_sa=r_sb=0 outside SEND.
- Minimum latency, when the responder echoes each bit the same cycle: r_rslt_valid rises in cycle E0+WIDTH+1 (33 cycles after accept for WIDTH=32).
- r_rslt_valid and r_rslt stay stable until the cycle after w_rslt_ready=1.
- w_in_ready rises the cycle after the result is taken, so back-to-back throughput is one transaction per WIDTH+2 cycles minimum.
- r_rslt retains the last completed result after leaving DONE.

## Test plan
- Loopback: bench ties w_rbit=r_sa, w_rv=r_sv, w_rslt_ready=1; sends w_rrs=0xDEADBEEF, w_rrt=0x12345678, w_sel=1.
  - Required: 32 serial bits with r_sfirst on cycle 1 and r_slast on cycle 32; r_ssel=1 throughout; r_rslt=0xDEADBEEF with r_rslt_valid high in cycle 33.
- Delayed, gapped result: bench ALU model computes 5+3; it returns bits starting 10 cycles after r_slast, with w_rv low every other cycle.
  - Required: r_rslt=0x00000008 only after the 32nd w_rv; state held in WAIT meanwhile.
- Result backpressure: w_rslt_ready=0 for 20 cycles in DONE.
  - Required: r_rslt_valid stays 1 and r_rslt is stable; w_in_ready stays 0; a concurrent w_in_valid with 0xFFFFFFFF is not accepted.
- Reset at serial bit 15 of a frame.
  - Required: next cycle r_sv=0, r_rslt_valid=0, r_rslt=0; w_in_ready=1 one cycle after reset deasserts; a new transaction with w_rrs=0x1 completes correctly.
- Stray bits: pulse w_rv=1 with w_rbit=1 for 5 cycles in IDLE, then run loopback with w_rrs=0.
  - Required: r_rslt=0x00000000, showing the stray bits were not counted.
- Extra rx bits: in SEND, drive w_rv=1 continuously with w_rbit=1.
  - Required: r_rslt=0xFFFFFFFF after exactly 32 bits; no overflow into the next transaction.

Source files
------------

// File: rtl/bitserial_link_driver_if.sv
// Parallel/serial signal bundle between the decode side, the link driver and the serial ALU.
// master = the link driver, slave = the surrounding decode logic and ALU.
interface bitserial_link_driver_if #(
    parameter int WIDTH = 32
);
    logic             w_in_valid;
    logic             w_in_ready;
    logic [WIDTH-1:0] w_rrs;
    logic [WIDTH-1:0] w_rrt;
    logic [3:0]       w_sel;
    logic             r_sa;
    logic             r_sb;
    logic             r_sv;
    logic             r_sfirst;
    logic             r_slast;
    logic [3:0]       r_ssel;
    logic             w_rbit;
    logic             w_rv;
    logic [WIDTH-1:0] r_rslt;
    logic             r_rslt_valid;
    logic             w_rslt_ready;

    modport master (
        input  w_in_valid, w_rrs, w_rrt, w_sel, w_rbit, w_rv, w_rslt_ready,
        output w_in_ready, r_sa, r_sb, r_sv, r_sfirst, r_slast, r_ssel,
               r_rslt, r_rslt_valid
    );

    modport slave (
        output w_in_valid, w_rrs, w_rrt, w_sel, w_rbit, w_rv, w_rslt_ready,
        input  w_in_ready, r_sa, r_sb, r_sv, r_sfirst, r_slast, r_ssel,
               r_rslt, r_rslt_valid
    );
endinterface

// File: rtl/bitserial_link_driver.sv
// Serialises an operand pair LSB-first to the bit-serial ALU and gathers its serial result
// back into a parallel word.
//
// state | meaning
// IDLE  | ready for an operand pair
// SEND  | streaming operand bits (receive also active)
// WAIT  | frame sent, still collecting result bits
// DONE  | result presented until the consumer takes it
module bitserial_link_driver #(
    parameter int WIDTH = 32
) (
    input logic                    w_clk,
    input logic                    w_rst,
    bitserial_link_driver_if.master bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    tx_cnt_q, tx_cnt_d;
    logic [CW-1:0]    rx_cnt_q, rx_cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [WIDTH-1:0] rslt_q, rslt_d;
    logic [3:0]       ssel_q, ssel_d;
    logic             sa_q, sa_d, sb_q, sb_d, sv_q, sv_d;
    logic             sfirst_q, sfirst_d, slast_q, slast_d;

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q  <= S_IDLE;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            rx_sh_q  <= '0;
            rslt_q   <= '0;
            ssel_q   <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            sv_q     <= 1'b0;
            sfirst_q <= 1'b0;
            slast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            rx_sh_q  <= rx_sh_d;
            rslt_q   <= rslt_d;
            ssel_q   <= ssel_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            sv_q     <= sv_d;
            sfirst_q <= sfirst_d;
            slast_q  <= slast_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tx_cnt_d = tx_cnt_q;
        rx_cnt_d = rx_cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        rx_sh_d  = rx_sh_q;
        rslt_d   = rslt_q;
        ssel_d   = ssel_q;
        sa_d     = 1'b0;
        sb_d     = 1'b0;
        sv_d     = 1'b0;
        sfirst_d = 1'b0;
        slast_d  = 1'b0;

        // Receive path; the count saturates so surplus bits never reach the result.
        if ((state_q == S_SEND || state_q == S_WAIT) && bus.w_rv && rx_cnt_q != CNT_FULL) begin
            rx_sh_d  = {bus.w_rbit, rx_sh_q[WIDTH-1:1]};
            rx_cnt_d = rx_cnt_q + CW'(1);
            if (rx_cnt_q == CNT_LAST) begin
                rslt_d = {bus.w_rbit, rx_sh_q[WIDTH-1:1]};
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bus.w_in_valid) begin
                    // Bit 0 is registered on the accept edge itself.
                    ssel_d   = bus.w_sel;
                    sa_d     = bus.w_rrs[0];
                    sb_d     = bus.w_rrt[0];
                    a_sh_d   = bus.w_rrs >> 1;
                    b_sh_d   = bus.w_rrt >> 1;
                    sv_d     = 1'b1;
                    sfirst_d = 1'b1;
                    tx_cnt_d = CW'(1);
                    rx_cnt_d = '0;
                    rx_sh_d  = '0;
                    state_d  = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_cnt_q == CNT_FULL) begin
                    state_d = (rx_cnt_d == CNT_FULL) ? S_DONE : S_WAIT;
                end else begin
                    sa_d     = a_sh_q[0];
                    sb_d     = b_sh_q[0];
                    a_sh_d   = a_sh_q >> 1;
                    b_sh_d   = b_sh_q >> 1;
                    sv_d     = 1'b1;
                    slast_d  = (tx_cnt_q == CNT_LAST);
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            S_WAIT: begin
                if (rx_cnt_q == CNT_FULL) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.w_rslt_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.w_in_ready   = (state_q == S_IDLE) && !w_rst;
    assign bus.r_rslt_valid = (state_q == S_DONE);
    assign bus.r_rslt       = rslt_q;
    assign bus.r_ssel       = ssel_q;
    assign bus.r_sa         = sa_q;
    assign bus.r_sb         = sb_q;
    assign bus.r_sv         = sv_q;
    assign bus.r_sfirst     = sfirst_q;
    assign bus.r_slast      = slast_q;
endmodule

// File: tb/tb_bitserial_link_driver.sv
// Bench for bitserial_link_driver: directed scenarios plus randomized transactions checked
// against a frame/ALU reference model.
module tb_bitserial_link_driver;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bitserial_link_driver_if #(.WIDTH(W)) bus ();

    bitserial_link_driver #(.WIDTH(W)) dut (
        .w_clk (clk),
        .w_rst (rst),
        .bus   (bus)
    );

    // Loopback responder echoes operand A bit-for-bit in the same cycle.
    logic lb;
    logic rbit_drv, rv_drv;
    assign bus.w_rbit = lb ? bus.r_sa : rbit_drv;
    assign bus.w_rv   = lb ? bus.r_sv : rv_drv;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [3:0] s);
        case (s)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a ^ b;
            4'd4:    return a | b;
            4'd5:    return a & b;
            default: return a;
        endcase
    endfunction

    // mode 0: loopback, 1: ALU model replying after dly cycles (optionally gapped),
    // 2: w_rv/w_rbit held at 1 throughout. hold = cycles of result backpressure.
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] sel,
                           input int mode, input int dly, input bit gapped, input int hold);
        logic [W-1:0] res, obs_a, obs_b, fm, lm;
        int svc, bits;
        bit found, ssel_ok, premature, bp_ok;
        res = (mode == 0) ? a : (mode == 2) ? '1 : alu(a, b, sel);
        lb = (mode == 0);
        rv_drv = (mode == 2);
        rbit_drv = (mode == 2);
        bus.w_rslt_ready = (hold == 0);
        svc = 0; ssel_ok = 1; premature = 0;
        obs_a = '0; obs_b = '0; fm = '0; lm = '0;

        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            found = bus.w_in_ready;
        end
        chk("in_ready", found, 1);
        bus.w_in_valid = 1'b1;
        bus.w_rrs = a;
        bus.w_rrt = b;
        bus.w_sel = sel;
        @(posedge clk);
        #1;
        bus.w_in_valid = 1'b0;
        bus.w_rrs = $urandom;
        bus.w_rrt = $urandom;
        bus.w_sel = 4'($urandom);

        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            obs_a[k] = bus.r_sa;
            obs_b[k] = bus.r_sb;
            fm[k] = bus.r_sfirst;
            lm[k] = bus.r_slast;
            svc += int'(bus.r_sv);
            if (bus.r_ssel !== sel) ssel_ok = 0;
            if (bus.r_rslt_valid) premature = 1;
        end
        chk("frame_a", obs_a, a);
        chk("frame_b", obs_b, b);
        chk("frame_sv_count", svc, W);
        chk("frame_first", fm, 1);
        chk("frame_last", lm, {1'b1, {(W-1){1'b0}}});
        chk("ssel_stable", ssel_ok, 1);

        @(negedge clk);
        chk("sv_after_frame", {bus.r_sv, bus.r_sa, bus.r_sb}, 0);
        if (mode != 1) begin
            chk("min_latency_valid", bus.r_rslt_valid, 1);
        end else begin
            bits = 0;
            for (int c = 1; bits < W && c < 400; c++) begin
                if (bus.r_rslt_valid) premature = 1;
                if (c >= dly && (!gapped || ((c - dly) % 2 == 0))) begin
                    if (bits == W - 1) chk("rslt_hold_before_last", bus.r_rslt, exp_last);
                    rv_drv = 1'b1;
                    rbit_drv = res[bits];
                    bits++;
                end else begin
                    rv_drv = 1'b0;
                    rbit_drv = 1'($urandom);
                end
                @(negedge clk);
            end
            rv_drv = 1'b0;
            chk("rx_bits_sent", bits, W);
            found = 0;
            for (int i = 0; i < 4 && !found; i++) begin
                if (bus.r_rslt_valid) found = 1;
                else @(negedge clk);
            end
            chk("done_timeout", found, 1);
        end
        chk("premature_valid", premature, 0);
        chk("rslt", bus.r_rslt, res);

        if (hold > 0) begin
            bus.w_in_valid = 1'b1;
            bus.w_rrs = '1;
            bp_ok = 1;
            for (int i = 0; i < hold; i++) begin
                if (!bus.r_rslt_valid || bus.r_rslt !== res || bus.w_in_ready) bp_ok = 0;
                @(negedge clk);
            end
            chk("backpressure_hold", bp_ok, 1);
            bus.w_in_valid = 1'b0;
            bus.w_rslt_ready = 1'b1;
            chk("bp_valid_still", bus.r_rslt_valid, 1);
        end
        @(negedge clk);
        chk("ready_after_take", bus.w_in_ready, 1);
        chk("valid_cleared", bus.r_rslt_valid, 0);
        chk("rslt_retained", bus.r_rslt, res);
        exp_last = res;
        lb = 1'b0;
        rv_drv = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] ra;
        int m;
        rst = 1'b1;
        lb = 1'b0;
        rv_drv = 1'b0;
        rbit_drv = 1'b0;
        bus.w_in_valid = 1'b0;
        bus.w_rrs = '0;
        bus.w_rrt = '0;
        bus.w_sel = '0;
        bus.w_rslt_ready = 1'b0;
        exp_last = '0;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.w_in_ready, 0);
        chk("rst_serial", {bus.r_sa, bus.r_sb, bus.r_sv, bus.r_sfirst, bus.r_slast}, 0);
        chk("rst_ssel", bus.r_ssel, 0);
        chk("rst_rslt", bus.r_rslt, 0);
        chk("rst_rslt_valid", bus.r_rslt_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", bus.w_in_ready, 1);

        run_txn(32'hDEADBEEF, 32'h12345678, 4'd1, 0, 0, 0, 0);
        run_txn(32'd5, 32'd3, 4'd1, 1, 10, 1, 20);

        // Abort in the middle of a frame.
        lb = 1'b1;
        bus.w_rslt_ready = 1'b1;
        bus.w_in_valid = 1'b1;
        bus.w_rrs = $urandom;
        bus.w_rrt = $urandom;
        bus.w_sel = 4'd3;
        @(posedge clk);
        #1;
        bus.w_in_valid = 1'b0;
        for (int k = 0; k < 16; k++) @(negedge clk);
        chk("mid_frame_sv", bus.r_sv, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_sv", bus.r_sv, 0);
        chk("abort_valid", bus.r_rslt_valid, 0);
        chk("abort_rslt", bus.r_rslt, 0);
        chk("abort_in_ready", bus.w_in_ready, 0);
        rst = 1'b0;
        exp_last = '0;
        @(negedge clk);
        chk("abort_ready_after", bus.w_in_ready, 1);
        lb = 1'b0;
        run_txn(32'h1, 32'($urandom), 4'd2, 0, 0, 0, 0);

        // Stray result bits while idle.
        rv_drv = 1'b1;
        rbit_drv = 1'b1;
        repeat (5) @(negedge clk);
        rv_drv = 1'b0;
        run_txn(32'h0, 32'($urandom), 4'd4, 0, 0, 0, 0);

        // Surplus rx bits, then a fresh transaction must be unaffected.
        run_txn(32'($urandom), 32'($urandom), 4'd5, 2, 0, 0, 0);
        ra = $urandom;
        run_txn(ra, 32'($urandom), 4'd1, 0, 0, 0, 0);

        for (int it = 0; it < 8; it++) begin
            m = (it % 2 == 0) ? 1 : int'($urandom_range(0, 2));
            run_txn(32'($urandom), 32'($urandom), 4'($urandom), m,
                    int'($urandom_range(1, 6)), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
